// File: rtl/checkbits_pkg.sv
// rtl/checkbits_pkg.sv - shared register offsets, reset constants and FSM states
package checkbits_pkg;

    localparam logic [2:0] ADR_CODE   = 3'd0;
    localparam logic [2:0] ADR_STATUS = 3'd1;
    localparam logic [2:0] ADR_CTRL   = 3'd2;
    localparam logic [2:0] ADR_MARKS  = 3'd3;
    localparam logic [2:0] ADR_CYCLES = 3'd4;

    localparam logic [15:0] START_DEF = 16'hAB50;
    localparam logic [15:0] END_DEF   = 16'hAB51;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/checkbits_fifo.sv
// rtl/checkbits_fifo.sv - synchronous 16-bit code FIFO with level/full/empty
module checkbits_fifo #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [15:0]                   s_tdata,
    input  logic                          s_tvalid,
    output logic                          s_tready,
    output logic [15:0]                   m_tdata,
    output logic                          m_tvalid,
    input  logic                          m_tready,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          full,
    output logic                          empty
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [15:0] mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        push;
    logic        pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign level    = wr_ptr - rd_ptr;
    assign empty    = (level == '0);
    assign full     = (level == (AW+1)'(FIFO_DEPTH));
    assign s_tready = ~full;
    assign m_tvalid = ~empty;
    assign m_tdata  = mem[rd_ptr[AW-1:0]];
    assign push     = s_tvalid & s_tready;
    assign pop      = m_tvalid & m_tready;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= s_tdata;
    end

endmodule

// File: rtl/checkbits_emitter.sv
// rtl/checkbits_emitter.sv - Wishbone checkpoint-code emitter with hold timer and cycle meter
module checkbits_emitter
    import checkbits_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int CNT_W       = 32
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [15:0] io_out,
    output logic [15:0] io_oeb
);

    localparam int LVL_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int HOLD_W = $clog2(HOLD_CYCLES) + 1;

    logic              wb_req;
    logic              wb_wr;
    logic [2:0]        reg_adr;
    logic              code_wr;
    logic              clr_wr;
    logic              ctrl_en;
    logic [15:0]       start_code;
    logic [15:0]       end_code;
    logic              overflow;
    logic              running;
    logic [CNT_W-1:0]  cycles;
    logic [CNT_W-1:0]  cycles_inc;
    state_t            state;
    state_t            state_d;
    logic [HOLD_W-1:0] hold;
    logic [HOLD_W-1:0] hold_d;
    logic              load;
    logic              fifo_ready;
    logic              fifo_valid;
    logic [15:0]       fifo_data;
    logic [LVL_W-1:0]  fifo_level;
    logic              fifo_full;
    logic              fifo_empty;
    logic [31:0]       rdata;
    logic              unused_bits;

    // The ack cycle itself never starts a new transfer.
    assign wb_req  = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
    assign wb_wr   = wb_req & wbs_we_i;
    assign reg_adr = wbs_adr_i[4:2];
    assign code_wr = wb_wr && (reg_adr == ADR_CODE) && (wbs_sel_i[1:0] == 2'b11);
    assign clr_wr  = wb_wr && (reg_adr == ADR_CTRL) && wbs_dat_i[1];
    assign io_oeb  = ctrl_en ? 16'h0000 : 16'hFFFF;

    assign unused_bits = ^{wbs_adr_i[31:5], wbs_adr_i[1:0], wbs_sel_i[3:2]};

    checkbits_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (wb_clk_i),
        .resetn   (wb_rst_n),
        .s_tdata  (wbs_dat_i[15:0]),
        .s_tvalid (code_wr),
        .s_tready (fifo_ready),
        .m_tdata  (fifo_data),
        .m_tvalid (fifo_valid),
        .m_tready (load),
        .level    (fifo_level),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_comb begin
        rdata = '0;
        case (reg_adr)
            ADR_CODE:   rdata = {16'h0000, io_out};
            ADR_STATUS: rdata = {23'd0, overflow, running, (state != IDLE),
                                 fifo_empty, fifo_full, 4'(fifo_level)};
            ADR_CTRL:   rdata = {31'd0, ctrl_en};
            ADR_MARKS:  rdata = {end_code, start_code};
            ADR_CYCLES: rdata = 32'(cycles);
            default:    rdata = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            wbs_ack_o  <= 1'b0;
            wbs_dat_o  <= '0;
            ctrl_en    <= 1'b0;
            start_code <= START_DEF;
            end_code   <= END_DEF;
            overflow   <= 1'b0;
        end else begin
            wbs_ack_o <= wb_req;
            wbs_dat_o <= (wb_req && !wbs_we_i) ? rdata : '0;
            if (wb_wr) begin
                case (reg_adr)
                    ADR_STATUS: if (wbs_dat_i[8]) overflow <= 1'b0;
                    ADR_CTRL:   ctrl_en <= wbs_dat_i[0];
                    ADR_MARKS: begin
                        start_code <= wbs_dat_i[15:0];
                        end_code   <= wbs_dat_i[31:16];
                    end
                    default: ;
                endcase
            end
            if (code_wr && !fifo_ready) overflow <= 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            state  <= IDLE;
            hold   <= '0;
            io_out <= '0;
        end else begin
            state <= state_d;
            hold  <= hold_d;
            if (load) io_out <= fifo_data;
        end
    end

    always_comb begin
        state_d = state;
        hold_d  = hold;
        load    = 1'b0;
        case (state)
            IDLE: begin
                if (fifo_valid) begin
                    load    = 1'b1;
                    hold_d  = HOLD_W'(HOLD_CYCLES - 1);
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (hold == '0) state_d = IDLE;
                else            hold_d  = hold - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    assign cycles_inc = (&cycles) ? cycles : cycles + CNT_W'(1);

    // The stopping edge still counts, so the frozen value equals the edge distance.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            cycles  <= '0;
            running <= 1'b0;
        end else if (clr_wr) begin
            cycles  <= '0;
            running <= 1'b0;
        end else if (load && (fifo_data == start_code) && !running) begin
            cycles  <= '0;
            running <= 1'b1;
        end else begin
            if (load && (fifo_data == end_code) && running) running <= 1'b0;
            if (running) cycles <= cycles_inc;
        end
    end

endmodule

// File: tb/tb_checkbits_emitter.sv
// tb/tb_checkbits_emitter.sv - self-checking bench for checkbits_emitter
module tb_checkbits_emitter;

    localparam int DEPTH = 4;
    localparam int HOLD  = 16;

    logic        wb_clk_i  = 1'b0;
    logic        wb_rst_n  = 1'b0;
    logic        wbs_cyc_i = 1'b0;
    logic        wbs_stb_i = 1'b0;
    logic        wbs_we_i  = 1'b0;
    logic [3:0]  wbs_sel_i = 4'h0;
    logic [31:0] wbs_adr_i = '0;
    logic [31:0] wbs_dat_i = '0;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic [15:0] io_out;
    logic [15:0] io_oeb;

    int tests = 0;
    int fails = 0;
    logic chk_on = 1'b0;

    checkbits_emitter #(
        .FIFO_DEPTH (DEPTH),
        .HOLD_CYCLES(HOLD),
        .CNT_W      (32)
    ) dut (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_n  (wb_rst_n),
        .wbs_cyc_i (wbs_cyc_i),
        .wbs_stb_i (wbs_stb_i),
        .wbs_we_i  (wbs_we_i),
        .wbs_sel_i (wbs_sel_i),
        .wbs_adr_i (wbs_adr_i),
        .wbs_dat_i (wbs_dat_i),
        .wbs_ack_o (wbs_ack_o),
        .wbs_dat_o (wbs_dat_o),
        .io_out    (io_out),
        .io_oeb    (io_oeb)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: queue of codes, a load allowed HOLD+1 edges after the
    // previous one, and a meter expressed as edge distances.
    int          n = 0;
    int          last_load = -1000;
    int          m_start_edge = 0;
    logic [15:0] q[$];
    logic [15:0] m_io = 16'h0;
    logic        m_en = 1'b0, m_ovf = 1'b0, m_run = 1'b0, m_ack = 1'b0, m_rd = 1'b0;
    logic [15:0] m_start = 16'hAB50, m_end = 16'hAB51;
    logic [31:0] m_frozen = '0, m_dat = '0;
    int          load_edge_log[$];
    logic [15:0] load_code_log[$];

    initial forever begin
        @(posedge wb_clk_i);
        n++;
        if (!wb_rst_n) begin
            q.delete();
            m_io = 16'h0; m_en = 1'b0; m_ovf = 1'b0; m_run = 1'b0;
            m_ack = 1'b0; m_rd = 1'b0; m_dat = '0; m_frozen = '0;
            m_start = 16'hAB50; m_end = 16'hAB51;
            last_load = -1000;
        end else begin
            logic        req, do_load, clr, push, busy;
            logic [2:0]  a;
            logic [31:0] rdv;
            int          pre_size;
            logic [15:0] pre_start, pre_end, code;
            req       = wbs_cyc_i && wbs_stb_i && !m_ack;
            a         = wbs_adr_i[4:2];
            pre_size  = q.size();
            pre_start = m_start;
            pre_end   = m_end;
            busy      = ((n - 1 - last_load) < HOLD);
            case (a)
                3'd0:    rdv = {16'h0, m_io};
                3'd1:    rdv = {23'h0, m_ovf, m_run, busy, (pre_size == 0), (pre_size == DEPTH), 4'(pre_size)};
                3'd2:    rdv = {31'h0, m_en};
                3'd3:    rdv = {m_end, m_start};
                3'd4:    rdv = m_run ? 32'(n - 1 - m_start_edge) : m_frozen;
                default: rdv = '0;
            endcase
            m_ack = req;
            m_rd  = req && !wbs_we_i;
            m_dat = m_rd ? rdv : '0;
            clr  = 1'b0;
            push = 1'b0;
            code = 16'h0;
            if (req && wbs_we_i) begin
                case (a)
                    3'd0: if (wbs_sel_i[1:0] == 2'b11) begin
                        if (pre_size < DEPTH) push = 1'b1;
                        else m_ovf = 1'b1;
                    end
                    3'd1: if (wbs_dat_i[8]) m_ovf = 1'b0;
                    3'd2: begin m_en = wbs_dat_i[0]; clr = wbs_dat_i[1]; end
                    3'd3: begin m_start = wbs_dat_i[15:0]; m_end = wbs_dat_i[31:16]; end
                    default: ;
                endcase
            end
            do_load = (pre_size > 0) && (n >= last_load + HOLD + 1);
            if (do_load) begin
                code = q.pop_front();
                m_io = code;
                last_load = n;
                load_edge_log.push_back(n);
                load_code_log.push_back(code);
            end
            if (clr) begin
                m_run = 1'b0;
                m_frozen = '0;
            end else if (do_load) begin
                if (code == pre_start && !m_run) begin
                    m_run = 1'b1;
                    m_start_edge = n;
                end else if (code == pre_end && m_run) begin
                    m_run = 1'b0;
                    m_frozen = 32'(n - m_start_edge);
                end
            end
            if (push) q.push_back(wbs_dat_i[15:0]);
        end
    end

    always @(negedge wb_clk_i) begin
        if (chk_on) begin
            check("io_out", {16'h0, io_out}, {16'h0, m_io});
            check("io_oeb", {16'h0, io_oeb}, m_en ? 32'h0 : 32'hFFFF);
            check("ack", {31'h0, wbs_ack_o}, {31'h0, m_ack});
            if (m_rd) check("rdata", wbs_dat_o, m_dat);
        end
    end

    task automatic wb_xfer(input logic we, input logic [2:0] a, input logic [31:0] d,
                           input logic [3:0] sel, output logic [31:0] rd);
        int k;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
        wbs_adr_i = {27'h0, a, 2'b00}; wbs_dat_i = d; wbs_sel_i = sel;
        k = 0;
        do begin
            @(negedge wb_clk_i);
            k++;
        end while (!wbs_ack_o && k < 10);
        check("wb_ack_seen", {31'h0, wbs_ack_o}, 32'h1);
        rd = wbs_dat_o;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        wb_xfer(1'b1, a, d, 4'hF, dummy);
    endtask

    task automatic rd_chk(input string name, input logic [2:0] a, input logic [31:0] exp);
        logic [31:0] v;
        wb_xfer(1'b0, a, 32'h0, 4'hF, v);
        check(name, v, exp);
    endtask

    initial begin
        logic [31:0] v;
        @(negedge wb_clk_i);
        wb_rst_n = 1'b0;
        repeat (3) @(negedge wb_clk_i);
        chk_on = 1'b1;
        wb_rst_n = 1'b1;

        // reset state
        rd_chk("reset_status", 3'd1, 32'h0000_0020);
        check("reset_oeb", {16'h0, io_oeb}, 32'h0000_FFFF);
        check("reset_io_out", {16'h0, io_out}, 32'h0);
        rd_chk("reset_marks", 3'd3, 32'hAB51_AB50);
        rd_chk("reset_ctrl", 3'd2, 32'h0);
        rd_chk("reset_cycles", 3'd4, 32'h0);

        // single code
        wr(3'd2, 32'h1);
        wr(3'd0, 32'h1234);
        @(negedge wb_clk_i);
        check("first_load", {16'h0, io_out}, 32'h1234);
        check("oeb_enabled", {16'h0, io_oeb}, 32'h0);
        rd_chk("status_busy", 3'd1, 32'h0000_0060);
        repeat (20) @(negedge wb_clk_i);
        rd_chk("status_idle", 3'd1, 32'h0000_0020);
        check("code_held", {16'h0, io_out}, 32'h1234);
        rd_chk("read_code", 3'd0, 32'h1234);

        // partial byte select is ignored; unmapped registers
        wb_xfer(1'b1, 3'd0, 32'hDEAD, 4'b0001, v);
        repeat (3) @(negedge wb_clk_i);
        rd_chk("sel_ignored", 3'd1, 32'h0000_0020);
        wr(3'd5, 32'hFFFF_FFFF);
        rd_chk("unmapped_read", 3'd5, 32'h0);

        // burst of ten: five survive, rest overflow
        load_edge_log.delete();
        load_code_log.delete();
        for (int i = 0; i < 10; i++) wr(3'd0, 32'h1001 + i);
        repeat (100) @(negedge wb_clk_i);
        rd_chk("status_overflow", 3'd1, 32'h0000_0120);
        check("burst_loads", load_code_log.size(), 32'd5);
        for (int i = 0; i < 5 && i < load_code_log.size(); i++)
            check("burst_code", {16'h0, load_code_log[i]}, 32'h1001 + i);
        for (int i = 1; i < load_edge_log.size(); i++)
            check("burst_spacing", load_edge_log[i] - load_edge_log[i-1], 32'd17);
        wr(3'd1, 32'h100);
        rd_chk("overflow_cleared", 3'd1, 32'h0000_0020);

        // cycle meter across four hold windows
        wr(3'd0, 32'hAB50);
        wr(3'd0, 32'h2371);
        wr(3'd0, 32'hBF5A);
        wr(3'd0, 32'h0050);
        wr(3'd0, 32'hAB51);
        repeat (100) @(negedge wb_clk_i);
        rd_chk("meter_68", 3'd4, 32'd68);
        rd_chk("meter_stopped", 3'd1, 32'h0000_0020);

        // START == END alternates
        wr(3'd3, 32'h5555_5555);
        wr(3'd0, 32'h5555);
        wr(3'd0, 32'h5555);
        repeat (60) @(negedge wb_clk_i);
        rd_chk("meter_same_mark", 3'd4, 32'd17);
        wr(3'd2, 32'h3);
        rd_chk("meter_clr", 3'd4, 32'h0);
        rd_chk("ctrl_clr_reads0", 3'd2, 32'h1);

        // reset during HOLD with three queued
        wr(3'd0, 32'h2001);
        wr(3'd0, 32'h2002);
        wr(3'd0, 32'h2003);
        wr(3'd0, 32'h2004);
        repeat (3) @(negedge wb_clk_i);
        wb_rst_n = 1'b0;
        @(negedge wb_clk_i);
        check("rst_io_out", {16'h0, io_out}, 32'h0);
        check("rst_oeb", {16'h0, io_oeb}, 32'h0000_FFFF);
        wb_rst_n = 1'b1;
        rd_chk("rst_status", 3'd1, 32'h0000_0020);
        repeat (60) @(negedge wb_clk_i);
        check("no_emit_after_rst", {16'h0, io_out}, 32'h0);
        rd_chk("rst_marks", 3'd3, 32'hAB51_AB50);
        rd_chk("rst_cycles", 3'd4, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
